// File: rtl/pong_pkg.sv
// Shared pong definitions: per-frame paddle direction encoding used by the
// button conditioner and both paddle blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        DIR_PUT   = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer followed by a restart-on-bounce debounce
// counter; stable only moves after DB_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int DB_CYCLES = 74250
) (
    input  logic pixel_clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam logic [16:0] CNT_LAST = 17'(DB_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic [16:0] cnt;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample matching stable throws away the partial count.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 17'd1;
            end
        end
    end

endmodule

// File: rtl/paddle_btn_cond.sv
// Paddle button conditioner: debounces both buttons, makes them mutually
// exclusive, emits press pulses and latches a direction once per frame.
module paddle_btn_cond
    import pong_pkg::*;
#(
    parameter int DB_CYCLES = 74250
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       fsync,
    input  logic       btn_right_raw,
    input  logic       btn_left_raw,
    output logic       right_out,
    output logic       left_out,
    output logic       press_right,
    output logic       press_left,
    output logic [1:0] dir_frame
);

    logic stable_r;
    logic stable_l;
    logic right_nx;
    logic left_nx;
    logic seen_r;
    logic seen_l;
    dir_t dir_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .raw       (btn_right_raw),
        .stable    (stable_r)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .raw       (btn_left_raw),
        .stable    (stable_l)
    );

    // Both held means neither: the paddle stays put rather than guessing.
    assign right_nx = stable_r & ~stable_l;
    assign left_nx  = stable_l & ~stable_r;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            right_out   <= 1'b0;
            left_out    <= 1'b0;
            press_right <= 1'b0;
            press_left  <= 1'b0;
            seen_r      <= 1'b0;
            seen_l      <= 1'b0;
            dir_q       <= DIR_PUT;
        end else begin
            right_out   <= right_nx;
            left_out    <= left_nx;
            press_right <= right_nx & ~right_out;
            press_left  <= left_nx & ~left_out;
            // The fsync cycle's own outputs still belong to the ending frame.
            if (fsync) begin
                seen_r <= 1'b0;
                seen_l <= 1'b0;
                if (seen_r | right_out)
                    dir_q <= DIR_RIGHT;
                else if (seen_l | left_out)
                    dir_q <= DIR_LEFT;
                else
                    dir_q <= DIR_PUT;
            end else begin
                seen_r <= seen_r | right_out;
                seen_l <= seen_l | left_out;
            end
        end
    end

    assign dir_frame = dir_q;

endmodule

// File: doc/paddle_btn_cond.md
PADDLE_BTN_COND -- requirements
Module: paddle_btn_cond

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 74250 (1 ms at 74.25 MHz), which is the number of cycles a raw level must hold before it is accepted; legal range is 2..131071.
REQ-002 The module SHALL have port pixel_clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port fsync, input, 1 bit: a one-cycle frame-start strobe.
REQ-005 The module SHALL have port btn_right_raw, input, 1 bit: asynchronous, bouncing right button.
REQ-006 The module SHALL have port btn_left_raw, input, 1 bit: asynchronous, bouncing left button.
REQ-007 The module SHALL have port right_out, output, 1 bit: debounced right level, feeding the paddle right input.
REQ-008 The module SHALL have port left_out, output, 1 bit: debounced left level, feeding the paddle left input.
REQ-009 The module SHALL have port press_right, output, 1 bit: one-cycle pulse on each accepted right press.
REQ-010 The module SHALL have port press_left, output, 1 bit: one-cycle pulse on each accepted left press.
REQ-011 The module SHALL have port dir_frame, output, 2 bits: per-frame direction, where 00 = PUT, 01 = LEFT and 10 = RIGHT.

Function
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other logic uses it.
REQ-013 Each button SHALL keep a stable bit and a 17-bit counter.
REQ-014 When sync2 equals stable, the counter SHALL be cleared to 0.
REQ-015 When sync2 differs from stable and the counter is below DB_CYCLES-1, the counter SHALL increment.
REQ-016 When sync2 differs from stable and the counter equals DB_CYCLES-1, stable SHALL take the value of sync2 and the counter SHALL be cleared.
REQ-017 Any bounce back to the stable value before acceptance SHALL restart the count from 0; there is no partial credit.
REQ-018 Latency: for a raw edge held constant, the registered outputs SHALL change exactly DB_CYCLES+3 rising edges after the first edge that samples the new raw value.
REQ-019 Mutual exclusion: registered right_out SHALL equal stable_r AND NOT stable_l, and left_out SHALL equal stable_l AND NOT stable_r; when both are stable-high, both outputs SHALL be 0.
REQ-020 press_right SHALL be high for exactly one cycle, the same cycle right_out goes 0->1; press_left SHALL behave the same for left_out.
REQ-021 A release (output 1->0) SHALL NOT produce a pulse.
REQ-022 Frame capture: sticky flags seen_r and seen_l SHALL be set on any cycle in which right_out or left_out, respectively, is 1.
REQ-023 On a cycle with fsync=1, dir_frame SHALL load RIGHT if (seen_r OR right_out), else LEFT if (seen_l OR left_out), else PUT.
REQ-024 On a cycle with fsync=1, both sticky flags SHALL clear to 0 in that same cycle, and the fsync cycle itself SHALL count toward the frame now ending.
REQ-025 When both directions were seen within one frame, RIGHT SHALL win.
REQ-026 dir_frame SHALL hold its value between fsync strobes.
REQ-027 fsync SHALL NOT affect the synchronizers, the debounce logic or the press pulses.

Reset
REQ-028 While rst=1, the sync flops, stable bits, counters, sticky flags and all outputs SHALL be 0, and dir_frame SHALL be PUT (00).
REQ-029 rst SHALL take priority over fsync and over any counter-terminal condition in the same cycle.
REQ-030 A press in progress at reset SHALL be discarded; after reset deassertion it SHALL require the full DB_CYCLES+3 edges again.
REQ-031 A button held through reset SHALL produce a press pulse after reset deassertion.

Structure
REQ-032 The DIR_PUT, DIR_LEFT and DIR_RIGHT constants and the 2-bit dir_t typedef SHALL be placed in the shared package pong_pkg, used by this block and by both paddle blocks.
REQ-033 The synchronizer, counter and stable bit SHALL be a sub-module btn_debounce (parameter DB_CYCLES; ports pixel_clk, rst, raw, stable), instantiated once per button.
REQ-034 Exclusion, pulse generation and frame capture SHALL reside in the top level.

Verification (DB_CYCLES=4 for simulation)
REQ-035 Clean press: btn_right_raw rises and is held -> right_out=1 and press_right=1 (one cycle) at edge 7; left_out stays 0; dir_frame=10 at the next fsync.
REQ-036 Bounce: btn_left_raw toggles 1,0 every 3 cycles for 30 cycles, then is held high -> no output activity during toggling; left_out rises 7 edges after the final rising edge.
REQ-037 Both pressed: right held, then left held 20 cycles later -> right_out falls when left is accepted, and left_out stays 0 throughout; dir_frame=10 at the next fsync.
REQ-038 Frame capture: a right press accepted and released between two fsyncs, then no input -> dir_frame=10 after the first fsync and 00 after the second.
REQ-039 Reset mid-count: rst asserted at count 2 while the right button is held -> outputs are 0 during reset; right_out rises 7 edges after rst deassertion.
REQ-040 fsync coincident with acceptance: right_out rises on an fsync cycle -> dir_frame=10 at that fsync; the next frame with the button still held also yields 10.
